sys_bus: RTL and testbench

// - Parametrised data-side interconnect between the Cpu data port and NSLV memory-mapped slaves (data RAM, MMIO, timers).
// - Generalises the single fixed data memory of the current system top: address decode, req/ack handshake, byte-lane steering,

---
 rtl/sys_bus_pkg.sv | 51 +++++
 rtl/sys_bus_lane_align.sv | 44 ++++
 rtl/sys_bus.sv | 195 +++++++++++++++++++
 tb/tb_sys_bus.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// sys_bus shared types and decode helpers.
// Memory op encoding, bus FSM states, byte-enable and error decode.
package sys_bus_pkg;

  typedef enum logic [2:0] {
    MOP_B  = 3'b000,
    MOP_H  = 3'b001,
    MOP_W  = 3'b010,
    MOP_BU = 3'b100,
    MOP_HU = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  function automatic logic is_byte(input logic [2:0] op);
    return (op == MOP_B) || (op == MOP_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    return (op == MOP_H) || (op == MOP_HU);
  endfunction

  function automatic logic [3:0] byte_en(
    input logic [2:0] op,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    if (is_byte(op)) be = 4'b0001 << off;
    else if (is_half(op)) be = 4'b0011 << off;
    return be;
  endfunction

  // Illegal op or an address not aligned to the access size.
  function automatic logic decode_err(
    input logic [2:0] op,
    input logic [1:0] off
  );
    logic e;
    e = 1'b1;
    if (is_byte(op)) e = 1'b0;
    else if (is_half(op)) e = off[0];
    else if (op == MOP_W) e = (off != 2'b00);
    return e;
  endfunction

endpackage

// File: rtl/sys_bus_lane_align.sv
// bus_lane_align: store lane replication and load lane extraction.
// Purely combinational; lane logic fixed to a 32-bit word.
module bus_lane_align
  import sys_bus_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [31:0] st_data,
  output logic [31:0] st_lanes,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  lb;
  logic [15:0] lh;

  // Replicate the right-aligned store datum across all lanes.
  always_comb begin
    st_lanes = st_data;
    if (is_byte(st_op)) st_lanes = {4{st_data[7:0]}};
    else if (is_half(st_op)) st_lanes = {2{st_data[15:0]}};
  end

  // Pick the addressed lane and extend it per op.
  always_comb begin
    unique case (ld_off)
      2'd0: lb = ld_word[7:0];
      2'd1: lb = ld_word[15:8];
      2'd2: lb = ld_word[23:16];
      default: lb = ld_word[31:24];
    endcase
    lh = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    unique case (1'b1)
      (ld_op == MOP_B):  ld_data = {{24{lb[7]}}, lb};
      (ld_op == MOP_BU): ld_data = {24'h0, lb};
      (ld_op == MOP_H):  ld_data = {{16{lh[15]}}, lh};
      (ld_op == MOP_HU): ld_data = {16'h0, lh};
      (ld_op == MOP_W):  ld_data = ld_word;
      default:           ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/sys_bus.sv
// sys_bus: data-side interconnect, CPU port to NSLV slaves.
// Optional BUS_TIMEOUT_EN: bounded WAIT with error on no ack.
module sys_bus
  import sys_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV = 4,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {NSLV{32'h0}},
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = {NSLV{32'h0}},
  parameter int TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_req,
  output logic                   cpu_ready,
  input  logic                   cpu_we,
  input  logic [2:0]             cpu_op,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_rvalid,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_err,
  output logic [NSLV-1:0]        s_sel,
  output logic                   s_we,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W/8-1:0]    s_be,
  output logic [DATA_W-1:0]      s_wdata,
  input  logic [NSLV-1:0]        s_ack,
  input  logic [NSLV*DATA_W-1:0] s_rdata
);

  if (DATA_W != 32 || NSLV < 1 || NSLV > 8 || TIMEOUT < 1)
  begin : g_bad_cfg
    $error("sys_bus: unsupported parameters");
  end

  bus_state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] off_q, off_d;
  logic ready_d, rvalid_d, err_d, we_d;
  logic [DATA_W-1:0] rdata_d, wdata_d;
  logic [NSLV-1:0] sel_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W/8-1:0] be_d;

  logic [NSLV-1:0] hit, hit1;
  logic [DATA_W-1:0] sel_word, st_lanes, ld_data;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  for (genvar i = 0; i < NSLV; i++) begin : g_dec
    assign hit[i] =
      (cpu_addr & SLV_MASK[i*ADDR_W +: ADDR_W])
      == SLV_BASE[i*ADDR_W +: ADDR_W];
  end

  // Lowest-index hit wins.
  assign hit1 = hit & (~hit + NSLV'(1));

  // Read word of the currently selected slave.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NSLV; i++)
      if (s_sel[i]) sel_word = sel_word | s_rdata[i*DATA_W +: DATA_W];
  end

  bus_lane_align u_align (
    .st_op    (cpu_op),
    .st_data  (cpu_wdata),
    .st_lanes (st_lanes),
    .ld_op    (op_q),
    .ld_off   (off_q),
    .ld_word  (sel_word),
    .ld_data  (ld_data)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    off_d    = off_q;
    ready_d  = cpu_ready;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    sel_d    = s_sel;
    we_d     = s_we;
    addr_d   = s_addr;
    be_d     = s_be;
    wdata_d  = s_wdata;
`ifdef BUS_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cpu_req) begin
          op_d    = cpu_op;
          off_d   = cpu_addr[1:0];
          ready_d = 1'b0;
          if (decode_err(cpu_op, cpu_addr[1:0]) || hit == '0) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = WAIT;
            sel_d   = hit1;
            we_d    = cpu_we;
            addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
            be_d    = byte_en(cpu_op, cpu_addr[1:0]);
            wdata_d = st_lanes;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      WAIT: begin
        if ((s_ack & s_sel) != '0) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = s_we ? '0 : ld_data;
          sel_d    = '0;
          we_d     = 1'b0;
          addr_d   = '0;
          be_d     = '0;
          wdata_d  = '0;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          sel_d    = '0;
          we_d     = 1'b0;
          addr_d   = '0;
          be_d     = '0;
          wdata_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= 3'b000;
      off_q      <= 2'b00;
      cpu_ready  <= 1'b1;
      cpu_rvalid <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      s_sel      <= '0;
      s_we       <= 1'b0;
      s_addr     <= '0;
      s_be       <= '0;
      s_wdata    <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      cpu_ready  <= ready_d;
      cpu_rvalid <= rvalid_d;
      cpu_err    <= err_d;
      cpu_rdata  <= rdata_d;
      s_sel      <= sel_d;
      s_we       <= we_d;
      s_addr     <= addr_d;
      s_be       <= be_d;
      s_wdata    <= wdata_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sys_bus.sv
// tb_sys_bus: directed bench for sys_bus, two slaves.
// Slave0 at 0x0000xxxx, slave1 at 0x0001xxxx.
module tb_sys_bus;
  import sys_bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req = 1'b0;
  logic        cpu_ready;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_op = 3'b000;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [1:0]  s_sel;
  logic        s_we;
  logic [31:0] s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic [1:0]  s_ack = '0;
  logic [63:0] s_rdata = '0;

  int checks = 0;
  int errors = 0;

  sys_bus #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .NSLV     (2),
    .SLV_BASE ({32'h0001_0000, 32'h0000_0000}),
    .SLV_MASK ({32'hFFFF_0000, 32'hFFFF_0000}),
    .TIMEOUT  (15)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_ready  (cpu_ready),
    .cpu_we     (cpu_we),
    .cpu_op     (cpu_op),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .s_sel      (s_sel),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_be       (s_be),
    .s_wdata    (s_wdata),
    .s_ack      (s_ack),
    .s_rdata    (s_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one edge; returns 1 time unit after accept.
  task automatic issue(input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_op = op;
    cpu_addr = addr;
    cpu_wdata = wd;
    step();
    cpu_req = 1'b0;
  endtask

  // Zero-wait transfer with full lane/response checks.
  task automatic xfer(input string tag, input logic we,
                      input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input int sl,
                      input logic [31:0] word, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic [31:0] erd);
    logic [1:0] esel;
    esel = 2'b01 << sl;
    chk({tag, ".ready0"}, {31'h0, cpu_ready}, 32'd1);
    issue(we, op, addr, wd);
    chk({tag, ".sel"}, {30'h0, s_sel}, {30'h0, esel});
    chk({tag, ".addr"}, s_addr, addr & 32'hFFFF_FFFC);
    chk({tag, ".be"}, {28'h0, s_be}, {28'h0, ebe});
    chk({tag, ".we"}, {31'h0, s_we}, {31'h0, we});
    if (we) chk({tag, ".wdata"}, s_wdata, ewd);
    chk({tag, ".rv_c1"}, {31'h0, cpu_rvalid}, 32'd0);
    chk({tag, ".busy"}, {31'h0, cpu_ready}, 32'd0);
    s_rdata[sl*32 +: 32] = word;
    s_ack[sl] = 1'b1;
    step();
    s_ack = '0;
    chk({tag, ".rv_c2"}, {31'h0, cpu_rvalid}, 32'd1);
    chk({tag, ".rdata"}, cpu_rdata, erd);
    chk({tag, ".err"}, {31'h0, cpu_err}, 32'd0);
    chk({tag, ".sel_off"}, {30'h0, s_sel}, 32'd0);
    step();
    chk({tag, ".rv_c3"}, {31'h0, cpu_rvalid}, 32'd0);
    chk({tag, ".ready1"}, {31'h0, cpu_ready}, 32'd1);
  endtask

  // Request that must fail without touching any slave.
  task automatic bad(input string tag, input logic [2:0] op,
                     input logic [31:0] addr);
    chk({tag, ".ready0"}, {31'h0, cpu_ready}, 32'd1);
    issue(1'b0, op, addr, 32'h0);
    chk({tag, ".rv"}, {31'h0, cpu_rvalid}, 32'd1);
    chk({tag, ".err"}, {31'h0, cpu_err}, 32'd1);
    chk({tag, ".sel"}, {30'h0, s_sel}, 32'd0);
    chk({tag, ".rdata"}, cpu_rdata, 32'd0);
    chk({tag, ".busy"}, {31'h0, cpu_ready}, 32'd0);
    step();
    chk({tag, ".rv_off"}, {31'h0, cpu_rvalid}, 32'd0);
    chk({tag, ".err_off"}, {31'h0, cpu_err}, 32'd0);
    chk({tag, ".ready1"}, {31'h0, cpu_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    step();
    step();
    chk("rst.ready", {31'h0, cpu_ready}, 32'd1);
    chk("rst.rvalid", {31'h0, cpu_rvalid}, 32'd0);
    chk("rst.err", {31'h0, cpu_err}, 32'd0);
    chk("rst.rdata", cpu_rdata, 32'd0);
    chk("rst.sel", {30'h0, s_sel}, 32'd0);
    chk("rst.we", {31'h0, s_we}, 32'd0);
    chk("rst.addr", s_addr, 32'd0);
    chk("rst.be", {28'h0, s_be}, 32'd0);
    chk("rst.wdata", s_wdata, 32'd0);
    reset = 1'b1;
    step();

    xfer("lw10", 1'b0, MOP_W, 32'h10, 32'h0, 0, 32'hDEADBEEF,
         4'b1111, 32'h0, 32'hDEADBEEF);
    xfer("lb13", 1'b0, MOP_B, 32'h13, 32'h0, 0, 32'h80FFFFFF,
         4'b1000, 32'h0, 32'hFFFFFF80);
    xfer("lbu13", 1'b0, MOP_BU, 32'h13, 32'h0, 0, 32'h80FFFFFF,
         4'b1000, 32'h0, 32'h00000080);
    xfer("lhu12", 1'b0, MOP_HU, 32'h12, 32'h0, 0, 32'h80FFFFFF,
         4'b1100, 32'h0, 32'h000080FF);
    xfer("lh12", 1'b0, MOP_H, 32'h12, 32'h0, 0, 32'h80FFFFFF,
         4'b1100, 32'h0, 32'hFFFF80FF);
    xfer("lb11", 1'b0, MOP_B, 32'h11, 32'h0, 0, 32'h1122_3344,
         4'b0010, 32'h0, 32'h00000033);
    xfer("lh10", 1'b0, MOP_H, 32'h10, 32'h0, 0, 32'h1122_8344,
         4'b0011, 32'h0, 32'hFFFF8344);
    xfer("lw_s1", 1'b0, MOP_W, 32'h0001_0004, 32'h0, 1, 32'h12345678,
         4'b1111, 32'h0, 32'h12345678);
    xfer("sh16", 1'b1, MOP_H, 32'h16, 32'hABCD_1234, 0, 32'hFFFFFFFF,
         4'b1100, 32'h12341234, 32'h0);
    chk("sh16.addr_hold", s_addr, 32'h0);
    xfer("sb11", 1'b1, MOP_B, 32'h11, 32'h0000_005A, 0, 32'h0,
         4'b0010, 32'h5A5A5A5A, 32'h0);
    xfer("sw_s1", 1'b1, MOP_W, 32'h0001_0008, 32'hCAFE_BABE, 1, 32'h0,
         4'b1111, 32'hCAFEBABE, 32'h0);

    bad("lw11", MOP_W, 32'h11);
    bad("lw12", MOP_W, 32'h12);
    bad("lh13", MOP_H, 32'h13);
    bad("nohit", MOP_W, 32'h0002_0000);
    bad("op011", 3'b011, 32'h10);
    bad("op111", 3'b111, 32'h10);

    // Wait states, foreign ack and a request while busy.
    issue(1'b0, MOP_W, 32'h20, 32'h0);
    s_ack = 2'b10;
    s_rdata[63:32] = 32'h5555_5555;
    cpu_req = 1'b1;
    cpu_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ws.rv", {31'h0, cpu_rvalid}, 32'd0);
      chk("ws.sel", {30'h0, s_sel}, 32'd1);
      chk("ws.addr", s_addr, 32'h20);
    end
    cpu_req = 1'b0;
    s_ack = 2'b01;
    s_rdata[31:0] = 32'hCAFE_F00D;
    step();
    s_ack = '0;
    chk("ws.rv1", {31'h0, cpu_rvalid}, 32'd1);
    chk("ws.rdata", cpu_rdata, 32'hCAFEF00D);
    step();
    step();
    chk("ws.noq_rv", {31'h0, cpu_rvalid}, 32'd0);
    chk("ws.noq_sel", {30'h0, s_sel}, 32'd0);
    chk("ws.noq_ready", {31'h0, cpu_ready}, 32'd1);

    // Reset in the middle of WAIT.
    issue(1'b0, MOP_W, 32'h30, 32'h0);
    chk("mr.sel_w", {30'h0, s_sel}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mr.sel", {30'h0, s_sel}, 32'd0);
    chk("mr.ready", {31'h0, cpu_ready}, 32'd1);
    chk("mr.be", {28'h0, s_be}, 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr.norv", {31'h0, cpu_rvalid}, 32'd0);
      chk("mr.ready1", {31'h0, cpu_ready}, 32'd1);
    end
    xfer("mr.lw", 1'b0, MOP_W, 32'h34, 32'h0, 0, 32'h0BADF00D,
         4'b1111, 32'h0, 32'h0BADF00D);

`ifdef BUS_TIMEOUT_EN
    // Silent slave: rvalid with err in cycle 17 after accept.
    issue(1'b0, MOP_W, 32'h40, 32'h0);
    for (int c = 1; c <= 16; c++) begin
      chk("to.wait", {31'h0, cpu_rvalid}, 32'd0);
      step();
    end
    chk("to.rv", {31'h0, cpu_rvalid}, 32'd1);
    chk("to.err", {31'h0, cpu_err}, 32'd1);
    chk("to.rdata", cpu_rdata, 32'd0);
    chk("to.sel", {30'h0, s_sel}, 32'd0);
    step();
    // Ack in the last counted cycle beats the timeout.
    issue(1'b0, MOP_W, 32'h44, 32'h0);
    for (int c = 1; c <= 15; c++) begin
      chk("tl.wait", {31'h0, cpu_rvalid}, 32'd0);
      step();
    end
    s_rdata[31:0] = 32'h600D_600D;
    s_ack = 2'b01;
    step();
    s_ack = '0;
    chk("tl.rv", {31'h0, cpu_rvalid}, 32'd1);
    chk("tl.err", {31'h0, cpu_err}, 32'd0);
    chk("tl.rdata", cpu_rdata, 32'h600D600D);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
